// File: rtl/norm_pkg.sv
// ----------------------------------------------------------------------------
// norm_pkg
//   Shared definitions for the norm scheduler: FSM state encoding and the
//   default count/result widths.
// ----------------------------------------------------------------------------
package norm_pkg;

   localparam int C_DEF = 20;   // width of channel counts and shared max
   localparam int S_DEF = 8;    // normalized result precision

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_STORE
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: returns the index of the first set bit of
//   pending_i at or after ptr_i, wrapping past N-1 back to 0.
// Ports
//   pending_i  in   N    request bits
//   ptr_i      in   IW   priority start index (0..N-1)
//   grant_o    out  IW   binary index of the selected channel
//   any_o      out  1    at least one request is pending
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  pending_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] grant_o,
   output logic          any_o
);

   // Scan from the farthest offset down to offset 0 so the nearest pending
   // channel to ptr_i is the last assignment and therefore wins.
   always_comb begin
      // NOTE: every output gets a default before the loop; without it a
      // cycle with no pending bit would leave grant_o unassigned and infer a latch.
      grant_o = '0;
      any_o   = |pending_i;
      for (int k = N - 1; k >= 0; k--) begin
         if (pending_i[(int'(ptr_i) + k) % N]) begin
            grant_o = IW'((int'(ptr_i) + k) % N);
         end
      end
   end

endmodule

// File: rtl/norm_sched.sv
// ----------------------------------------------------------------------------
// norm_sched
//   Round-robin scheduler sharing one norm divider among N channel counters.
//   Requests latch into pending bits; each granted channel snapshots its count
//   and the shared max, and either resolves locally (max==0 -> 0,
//   count>=max -> all ones) or runs the divider start/ready handshake.
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   req          in  N     per-channel request level, sampled every cycle
//   count        in  N*C   channel counts, channel i at [i*C +: C]
//   max          in  C     shared full-scale value
//   norm_start   out 1     one-cycle divider start pulse
//   norm_count   out C     snapshotted count for the divider
//   norm_max     out C     snapshotted max for the divider
//   norm_count_nm in S     divider result
//   norm_ready   in  1     divider idle / result valid
//   result       out N*S   latest normalized value per channel, [i*S +: S]
//   done         out N     one-cycle pulse when result[i] updates
//   busy         out 1     scheduler not idle
//   err          out 1     sticky: divider never acknowledged a start
// ----------------------------------------------------------------------------
module norm_sched
   import norm_pkg::*;
#(
   parameter int N      = 4,
   parameter int C      = C_DEF,
   parameter int S      = S_DEF,
   parameter int ACK_TO = 4
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic [N-1:0]   req,
   input  logic [N*C-1:0] count,
   input  logic [C-1:0]   max,
   output logic           norm_start,
   output logic [C-1:0]   norm_count,
   output logic [C-1:0]   norm_max,
   input  logic [S-1:0]   norm_count_nm,
   input  logic           norm_ready,
   output logic [N*S-1:0] result,
   output logic [N-1:0]   done,
   output logic           busy,
   output logic           err
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = $clog2(ACK_TO + 1);

   sched_state_t  state_q;
   logic [N-1:0]  pending_q;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] grant_q;
   logic [S-1:0]  staged_q;
   logic [AW-1:0] ack_cnt_q;

   logic [IW-1:0] arb_idx;
   logic          arb_any;
   logic [C-1:0]  snap_count;
   logic [N-1:0]  grant_clr;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_arb (
      .pending_i (pending_q),
      .ptr_i     (ptr_q),
      .grant_o   (arb_idx),
      .any_o     (arb_any)
   );

   assign snap_count = count[int'(arb_idx) * C +: C];

   // The granted bit is cleared in GRANT, but a req seen in the same cycle
   // is OR-ed back in afterwards so it is not lost.
   assign grant_clr = (state_q == ST_GRANT) ? (N'(1) << arb_idx) : '0;

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         // NOTE: result is a flat register (not a RAM), so clearing it in
         // reset is cheap and keeps stale values from an abandoned job out.
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         ptr_q      <= '0;
         grant_q    <= '0;
         staged_q   <= '0;
         ack_cnt_q  <= '0;
         norm_start <= 1'b0;
         norm_count <= '0;
         norm_max   <= '0;
         result     <= '0;
         done       <= '0;
         err        <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; every register here updates from
         // the values present at the edge, never from one another mid-block.
         pending_q  <= (pending_q & ~grant_clr) | req;
         norm_start <= 1'b0;
         done       <= '0;

         case (state_q)
            ST_IDLE: begin
               if (arb_any && norm_ready) state_q <= ST_GRANT;
            end

            ST_GRANT: begin
               grant_q    <= arb_idx;
               ptr_q      <= (arb_idx == IW'(N - 1)) ? '0 : arb_idx + IW'(1);
               norm_count <= snap_count;
               norm_max   <= max;
               if (max == '0) begin
                  staged_q <= '0;
                  state_q  <= ST_STORE;
               end else if (snap_count >= max) begin
                  staged_q <= '1;
                  state_q  <= ST_STORE;
               end else begin
                  norm_start <= 1'b1;
                  state_q    <= ST_ISSUE;
               end
            end

            // norm_start is high during this state only.
            ST_ISSUE: begin
               ack_cnt_q <= '0;
               state_q   <= ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
               if (!norm_ready) begin
                  state_q <= ST_WAIT_DONE;
               end else if (ack_cnt_q == AW'(ACK_TO - 1)) begin
                  err     <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  ack_cnt_q <= ack_cnt_q + AW'(1);
               end
            end

            ST_WAIT_DONE: begin
               if (norm_ready) begin
                  staged_q <= norm_count_nm;
                  state_q  <= ST_STORE;
               end
            end

            ST_STORE: begin
               result[int'(grant_q) * S +: S] <= staged_q;
               done    <= N'(1) << grant_q;
               state_q <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_sched.sv
// ----------------------------------------------------------------------------
// tb_norm_sched
//   Directed bench for norm_sched with a behavioural divider model. Stimulus
//   pushes hand-computed {channel, value} pairs into a scoreboard queue; a
//   monitor pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_norm_sched;

   localparam int N      = 4;
   localparam int C      = 20;
   localparam int S      = 8;
   localparam int ACK_TO = 4;
   localparam int LAT    = 6;

   typedef struct {
      int          ch;
      logic [7:0]  val;
   } sb_entry_t;

   logic           clk;
   logic           nrst;
   logic [N-1:0]   req;
   logic [N*C-1:0] count;
   logic [C-1:0]   max;
   logic           norm_start;
   logic [C-1:0]   norm_count;
   logic [C-1:0]   norm_max;
   logic [S-1:0]   norm_count_nm;
   logic           norm_ready;
   logic [N*S-1:0] result;
   logic [N-1:0]   done;
   logic           busy;
   logic           err;

   logic           tie_ready;
   logic [3:0]     lat_q;
   logic [S-1:0]   res_q;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   sb_entry_t sb[$];
   sb_entry_t e_mon;

   norm_sched #(
      .N(N), .C(C), .S(S), .ACK_TO(ACK_TO)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .req           (req),
      .count         (count),
      .max           (max),
      .norm_start    (norm_start),
      .norm_count    (norm_count),
      .norm_max      (norm_max),
      .norm_count_nm (norm_count_nm),
      .norm_ready    (norm_ready),
      .result        (result),
      .done          (done),
      .busy          (busy),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Divider model: accepts start while ready, drops ready, returns
   // floor(count*2^S/max) after LAT cycles. tie_ready makes it ignore start.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         norm_ready    <= 1'b1;
         lat_q         <= '0;
         res_q         <= '0;
         norm_count_nm <= '0;
      end else if (!norm_ready) begin
         if (lat_q == 0) begin
            norm_ready    <= 1'b1;
            norm_count_nm <= res_q;
         end else begin
            lat_q <= lat_q - 4'd1;
         end
      end else if (norm_start && !tie_ready) begin
         logic [31:0] q;
         q = (norm_max == 0) ? 32'd0 : ({12'd0, norm_count} << S) / {12'd0, norm_max};
         norm_ready <= 1'b0;
         lat_q      <= 4'(LAT);
         res_q      <= q[S-1:0];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard comparison on each done pulse.
   always @(negedge clk) begin
      if (nrst) begin
         if (norm_start) start_cnt++;
         if (done != '0) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("done_unexpected", 32'(done), 32'd0);
            end else begin
               e_mon = sb.pop_front();
               check("done_onehot", 32'(done), 32'(1) << e_mon.ch);
               check("result_value", 32'(result[e_mon.ch*S +: S]), 32'(e_mon.val));
            end
         end
      end
   end

   task automatic push(input int ch, input logic [7:0] val);
      sb_entry_t e;
      e.ch  = ch;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic set_count(input int ch, input logic [C-1:0] v);
      count[ch*C +: C] = v;
   endtask

   // Holds req for 'cycles' sampling edges; returns #1 after the last one.
   task automatic pulse_req(input logic [N-1:0] r, input int cycles);
      @(posedge clk); #1;
      req = r;
      repeat (cycles) @(posedge clk);
      #1;
      req = '0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check(name, 32'(done_cnt), 32'(target));
   endtask

   task automatic wait_start(input int target, input string name);
      int n = 0;
      while (start_cnt < target && n < 100) begin
         @(posedge clk);
         n++;
      end
      check(name, 32'(start_cnt), 32'(target));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   initial begin
      int s0;
      int d0;
      nrst      = 1'b0;
      req       = '0;
      count     = '0;
      max       = '0;
      tie_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state.
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(norm_start), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_result", result, 32'd0);
      nrst = 1'b1;

      // Single request through the divider: 0x3AA7/0x754E = 1/2 -> 128.
      // max is changed mid-job and must not affect it.
      max = 20'h0754E;
      set_count(0, 20'h03AA7);
      push(0, 8'd128);
      s0 = start_cnt;
      pulse_req(4'b0001, 1);
      wait_start(s0 + 1, "single_start");
      @(posedge clk); #1;
      max = 20'h0;
      wait_done(1, "single_done");
      check("single_starts", 32'(start_cnt), 32'(s0 + 1));
      check("single_snap_count", 32'(norm_count), 32'h03AA7);
      check("single_snap_max", 32'(norm_max), 32'h0754E);
      max = 20'h0754E;

      // Saturation (count == max): local result, done exactly 3 edges after req.
      set_count(1, 20'h0754E);
      push(1, 8'hFF);
      s0 = start_cnt;
      pulse_req(4'b0010, 1);
      @(posedge clk);
      @(posedge clk); #1;
      check("sat_done_early", 32'(done), 32'd0);
      check("sat_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("sat_done_k3", 32'(done), 32'b0010);
      wait_done(2, "sat_done");
      check("sat_no_start", 32'(start_cnt), 32'(s0));

      // max == 0: local zero result, no error.
      max = 20'h0;
      set_count(2, 20'h00123);
      push(2, 8'h00);
      s0 = start_cnt;
      pulse_req(4'b0100, 1);
      wait_done(3, "max0_done");
      check("max0_no_start", 32'(start_cnt), 32'(s0));
      check("max0_err", 32'(err), 32'd0);

      // req held across its own grant cycle: channel 0 serviced twice.
      max = 20'h04000;
      set_count(0, 20'h01000);
      push(0, 8'h40);
      push(0, 8'h40);
      pulse_req(4'b0001, 3);
      wait_done(5, "regrant_done");

      // All four requesting after reset: order 0,1,2,3.
      do_reset();
      d0 = done_cnt;
      max = 20'h04000;
      set_count(0, 20'h01000);
      set_count(1, 20'h02000);
      set_count(2, 20'h0754E);
      set_count(3, 20'h00000);
      push(0, 8'h40);
      push(1, 8'h80);
      push(2, 8'hFF);
      push(3, 8'h00);
      s0 = start_cnt;
      pulse_req(4'b1111, 1);
      @(posedge clk); #1;
      check("rr_busy", 32'(busy), 32'd1);
      wait_done(d0 + 4, "rr_done");
      check("rr_starts", 32'(start_cnt), 32'(s0 + 3));
      check("rr_idle", 32'(busy), 32'd0);

      // Divider never acknowledges: err after ACK_TO cycles, no done.
      d0 = done_cnt;
      tie_ready = 1'b1;
      set_count(0, 20'h01000);
      pulse_req(4'b0001, 1);
      repeat (3) @(posedge clk);
      #1;
      check("ackto_err_early", 32'(err), 32'd0);
      repeat (9) @(posedge clk);
      #1;
      check("ackto_err", 32'(err), 32'd1);
      check("ackto_no_done", 32'(done_cnt), 32'(d0));
      check("ackto_idle", 32'(busy), 32'd0);
      tie_ready = 1'b0;
      set_count(1, 20'h02000);
      push(1, 8'h80);
      pulse_req(4'b0010, 1);
      wait_done(d0 + 1, "ackto_recover");
      check("ackto_err_sticky", 32'(err), 32'd1);

      // Reset while waiting for the divider: job abandoned.
      d0 = done_cnt;
      s0 = start_cnt;
      set_count(2, 20'h01000);
      pulse_req(4'b0100, 1);
      wait_start(s0 + 1, "rstmid_start");
      @(posedge clk);
      @(posedge clk); #1;
      check("rstmid_busy_before", 32'(busy), 32'd1);
      nrst = 1'b0;
      #1;
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_start", 32'(norm_start), 32'd0);
      check("rstmid_done", 32'(done), 32'd0);
      check("rstmid_result", result, 32'd0);
      check("rstmid_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      nrst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("rstmid_no_store", 32'(done_cnt), 32'(d0));
      check("rstmid_result_after", result, 32'd0);
      check("rstmid_idle", 32'(busy), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
